tlc_multi_combiner: RTL and testbench

Parametrised traffic-light phase combiner for an N-direction intersection. Per-direction requests are latched, arbitrated round-robin, and each granted direction is driven through a full phase: green (minimum time, extendable), yellow, all-red clearance. All other direction fields stay red. The block sits between the request/sensor logic and the lamp drivers, and supersedes the fixed three-direction combiner by providing internal phase timing, request queuing and green extension.

---
 rtl/tlc_multi_combiner_if.sv | 18 +
 rtl/tlc_multi_combiner.sv | 126 ++++++++++++
 tb/tb_tlc_multi_combiner.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlc_multi_combiner_if.sv
// Request/lamp bundle between the sensor-side requester and the phase combiner.
// No backpressure: req is a level or one-cycle pulse, the combiner latches it; outputs are registered-state decodes.
interface tlc_multi_combiner_if #(
    parameter int N_DIR = 4
) ();
    localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

    logic [N_DIR-1:0]   req;
    logic [3*N_DIR-1:0] lights;
    logic [N_DIR-1:0]   grant;
    logic [DIR_W-1:0]   cur_dir;
    logic               busy;
    logic               ok;
    logic [1:0]         dbg_state;

    modport master (output req, input lights, grant, cur_dir, busy, ok, dbg_state);
    modport slave  (input req, output lights, grant, cur_dir, busy, ok, dbg_state);
endinterface

// File: rtl/tlc_multi_combiner.sv
// N-direction traffic-light phase combiner: latched requests, round-robin grant,
// green (min + extension) -> yellow -> all-red per granted direction.
module tlc_multi_combiner #(
    parameter int N_DIR      = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tlc_multi_combiner_if.slave  bus
);
    localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_ALLRED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_DIR-1:0]   pending_q, pending_d;
    logic [DIR_W-1:0]   last_q, last_d;
    logic [DIR_W-1:0]   cur_q, cur_d;

    logic [N_DIR-1:0]   cur_mask;
    logic [N_DIR-1:0]   cand;
    logic [DIR_W-1:0]   win;
    logic               win_found;
    logic               enter_green;
    logic [3*N_DIR-1:0] lights;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            last_q    <= DIR_W'(N_DIR - 1);
            cur_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            cur_q     <= cur_d;
        end
    end

    // The green direction may not re-nominate itself; that is what lets others preempt extension.
    always_comb begin
        cur_mask  = N_DIR'(1) << cur_q;
        cand      = pending_q | bus.req;
        if (state_q == S_GREEN) cand = cand & ~cur_mask;
        win       = '0;
        win_found = 1'b0;
        for (int k = 0; k < N_DIR; k++) begin
            if (!win_found && cand[(int'(last_q) + 1 + k) % N_DIR]) begin
                win_found = 1'b1;
                win       = DIR_W'((int'(last_q) + 1 + k) % N_DIR);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        cur_d       = cur_q;
        enter_green = 1'b0;
        pending_d   = pending_q | (bus.req & ((state_q == S_GREEN) ? ~cur_mask : '1));
        case (state_q)
            S_IDLE: begin
                if (win_found) enter_green = 1'b1;
            end
            S_GREEN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (cand != '0 || !bus.req[cur_q]) begin
                    state_d = S_YELLOW;
                    cnt_d   = CNT_W'(YELLOW_CYC - 1);
                end
            end
            S_YELLOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_ALLRED;
                    cnt_d   = CNT_W'(ALLRED_CYC - 1);
                end
            end
            S_ALLRED: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else if (win_found) enter_green = 1'b1;
                else state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Granting clears the winner's pending bit even if it is requesting this same cycle.
        if (enter_green) begin
            state_d        = S_GREEN;
            cnt_d          = CNT_W'(GREEN_CYC - 1);
            last_d         = win;
            cur_d          = win;
            pending_d[win] = 1'b0;
        end
    end

    always_comb begin
        lights = {N_DIR{L_RED}};
        if (state_q == S_GREEN)  lights[3*int'(cur_q) +: 3] = L_GRN;
        if (state_q == S_YELLOW) lights[3*int'(cur_q) +: 3] = L_YEL;
    end

    assign bus.lights    = lights;
    assign bus.grant     = (state_q != S_IDLE) ? cur_mask : '0;
    assign bus.cur_dir   = cur_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ok        = (state_q == S_ALLRED) && (cnt_q == '0);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_tlc_multi_combiner.sv
// Directed bench for tlc_multi_combiner: a phase-timeline model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_tlc_multi_combiner;
    localparam int N = 4;
    localparam int G = 8;
    localparam int Y = 3;
    localparam int A = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    tlc_multi_combiner_if #(.N_DIR(N)) bus ();

    tlc_multi_combiner #(
        .N_DIR(N), .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: a phase is a timeline of m_glen green cycles, Y yellow, A all-red; m_t is the position in it.
    int           m_dir;
    int           m_t;
    int           m_glen;
    int           m_last;
    int           m_cur;
    logic [N-1:0] m_pend;

    function automatic bit in_green();
        return (m_dir >= 0) && (m_t < m_glen);
    endfunction

    function automatic logic [N-1:0] own_mask();
        return (m_dir >= 0) ? (N'(1) << m_dir) : '0;
    endfunction

    function automatic logic [N-1:0] cand_of(logic [N-1:0] rq);
        logic [N-1:0] c = m_pend | rq;
        if (in_green()) c = c & ~own_mask();
        return c;
    endfunction

    function automatic int pick(logic [N-1:0] rq);
        logic [N-1:0] c = cand_of(rq);
        for (int k = 0; k < N; k++)
            if (c[(m_last + 1 + k) % N]) return (m_last + 1 + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] new_pend(logic [N-1:0] rq);
        return m_pend | (rq & (in_green() ? ~own_mask() : '1));
    endfunction

    function automatic bit extend(logic [N-1:0] rq);
        return in_green() && (m_t == m_glen - 1) && (cand_of(rq) == '0) && rq[m_dir];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dir  <= -1;
            m_t    <= 0;
            m_glen <= G;
            m_last <= N - 1;
            m_cur  <= 0;
            m_pend <= '0;
        end else if (m_dir < 0 || m_t == m_glen + Y + A - 1) begin
            if (pick(bus.req) >= 0) begin
                m_dir  <= pick(bus.req);
                m_t    <= 0;
                m_glen <= G;
                m_last <= pick(bus.req);
                m_cur  <= pick(bus.req);
                m_pend <= new_pend(bus.req) & ~(N'(1) << pick(bus.req));
            end else begin
                m_dir  <= -1;
                m_pend <= new_pend(bus.req);
            end
        end else begin
            m_t    <= m_t + 1;
            m_pend <= new_pend(bus.req);
            if (extend(bus.req)) m_glen <= m_glen + 1;
        end
    end

    function automatic logic [3*N-1:0] exp_lights();
        logic [3*N-1:0] l = {N{3'b100}};
        if (m_dir >= 0) begin
            if (m_t < m_glen)          l[3*m_dir +: 3] = 3'b001;
            else if (m_t < m_glen + Y) l[3*m_dir +: 3] = 3'b010;
        end
        return l;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: step to the falling edge and compare every output against the model.
    task automatic cyc();
        int lit;
        @(negedge clk);
        if (!rst) begin
            check("lights", 64'(bus.lights), 64'(exp_lights()));
            check("grant", 64'(bus.grant), 64'(own_mask()));
            check("cur_dir", 64'(bus.cur_dir), 64'(m_cur));
            check("busy", 64'(bus.busy), 64'(m_dir >= 0));
            check("ok", 64'(bus.ok), 64'((m_dir >= 0) && (m_t == m_glen + Y + A - 1)));
            lit = 0;
            for (int i = 0; i < N; i++) if (bus.lights[3*i +: 3] != 3'b100) lit++;
            check("one_lit", 64'(lit <= 1), 64'(1));
        end
    endtask

    task automatic reset_dut();
        bus.req = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int b;
        int g;
        int yl;
        int r;
        int okc;
        int okat;
        int order[6];
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        bus.req  = '0;

        // Reset values and idle hold
        repeat (3) cyc();
        check("rst_lights", 64'(bus.lights), 64'(12'h924));
        check("rst_grant", 64'(bus.grant), 64'(0));
        check("rst_cur", 64'(bus.cur_dir), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_ok", 64'(bus.ok), 64'(0));
        rst = 1'b0;
        b = 0;
        repeat (20) begin cyc(); if (bus.busy) b++; end
        check("idle_hold", 64'(b), 64'(0));

        // Single pulse on dir 2
        bus.req = 4'b0100;
        g = 0; yl = 0; r = 0; okc = 0; okat = 0;
        for (int i = 1; i <= 13; i++) begin
            cyc();
            if (i == 1) bus.req = '0;
            if (bus.lights[8:6] == 3'b001) g++;
            if (bus.lights[8:6] == 3'b010) yl++;
            if (bus.lights[8:6] == 3'b100) r++;
            if (bus.ok) begin okc++; okat = i; end
        end
        check("single_green", 64'(g), 64'(8));
        check("single_yellow", 64'(yl), 64'(3));
        check("single_red", 64'(r), 64'(2));
        check("single_ok_cnt", 64'(okc), 64'(1));
        check("single_ok_at", 64'(okat), 64'(13));
        cyc();
        check("single_idle", 64'(bus.busy), 64'(0));

        // Asynchronous reset mid-yellow of dir 0 (last=2, so dir 0 wins)
        bus.req = 4'b0001;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            if (i == 1) bus.req = '0;
        end
        check("pre_rst_yellow", 64'(bus.lights[2:0]), 64'(3'b010));
        #3;
        rst = 1'b1;
        #1;
        check("arst_lights", 64'(bus.lights), 64'(12'h924));
        check("arst_grant", 64'(bus.grant), 64'(0));
        check("arst_busy", 64'(bus.busy), 64'(0));
        cyc();
        cyc();
        rst = 1'b0;

        // Simultaneous pulse 1011: order 0,1,3 back-to-back
        bus.req = 4'b1011;
        okc = 0;
        for (int i = 1; i <= 39; i++) begin
            cyc();
            if (i == 1) bus.req = '0;
            if (i == 1)  order[0] = int'(bus.cur_dir);
            if (i == 14) order[1] = int'(bus.cur_dir);
            if (i == 27) order[2] = int'(bus.cur_dir);
            if (bus.ok) okc++;
        end
        check("simul_first", 64'(order[0]), 64'(0));
        check("simul_second", 64'(order[1]), 64'(1));
        check("simul_third", 64'(order[2]), 64'(3));
        check("simul_ok_cnt", 64'(okc), 64'(3));
        cyc();
        check("simul_idle", 64'(bus.busy), 64'(0));

        // Extension on dir 1, preempted by req[3] at cycle 20
        reset_dut();
        bus.req = 4'b0010;
        g = 0;
        for (int i = 1; i <= 26; i++) begin
            cyc();
            if (bus.lights[5:3] == 3'b001) g++;
            if (i == 20) bus.req = 4'b1010;
            if (i == 21) begin
                check("ext_yellow", 64'(bus.lights[5:3]), 64'(3'b010));
                bus.req = '0;
            end
            if (i == 24) check("ext_allred", 64'(bus.lights), 64'(12'h924));
            if (i == 26) begin
                check("ext_dir3_green", 64'(bus.lights[11:9]), 64'(3'b001));
                check("ext_dir3_cur", 64'(bus.cur_dir), 64'(3));
            end
        end
        check("ext_green_len", 64'(g), 64'(20));

        // Fairness with all requests held
        reset_dut();
        bus.req = 4'b1111;
        g = 0;
        for (int i = 1; i <= 78; i++) begin
            cyc();
            if (i % 13 == 1) order[i / 13] = int'(bus.cur_dir);
            if (bus.lights != 12'h924 && bus.lights[3*int'(bus.cur_dir) +: 3] == 3'b001) g++;
        end
        check("fair_0", 64'(order[0]), 64'(0));
        check("fair_1", 64'(order[1]), 64'(1));
        check("fair_2", 64'(order[2]), 64'(2));
        check("fair_3", 64'(order[3]), 64'(3));
        check("fair_4", 64'(order[4]), 64'(0));
        check("fair_5", 64'(order[5]), 64'(1));
        check("fair_green_total", 64'(g), 64'(48));

        // Re-request during yellow of dir 2
        reset_dut();
        bus.req = 4'b0100;
        b = 0;
        for (int i = 1; i <= 14; i++) begin
            cyc();
            if (bus.busy) b++;
            if (i == 1)  bus.req = '0;
            if (i == 9)  bus.req = 4'b0100;
            if (i == 10) bus.req = '0;
        end
        check("rereq_busy", 64'(b), 64'(14));
        check("rereq_green", 64'(bus.lights[8:6]), 64'(3'b001));
        check("rereq_cur", 64'(bus.cur_dir), 64'(2));

        // Request overlapping the grant edge is served once
        reset_dut();
        bus.req = 4'b0100;
        for (int i = 1; i <= 14; i++) begin
            cyc();
            if (i == 2) bus.req = '0;
        end
        check("once_idle", 64'(bus.busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
